simon_sequencer: RTL and testbench

Pattern sequencer that consumes the 2-bit random symbols from the random generator to build a growing memory-game sequence. Each round appends one symbol, replays the whole sequence on the display outputs and then checks the player's key presses against it. It sits directly downstream of the generator: it raises `go1` for one cycle per round and captures `rand_in` in that same cycle. It drives the LED/HEX display stage and the win/lose status.

---
 rtl/simon_pkg.sv | 17 +
 rtl/simon_sequencer_if.sv | 34 +++
 rtl/simon_sequencer_tick_timer.sv | 38 +++
 rtl/simon_sequencer.sv | 156 +++++++++++++++
 tb/tb_simon_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared types for the simon memory-game sequencer.
// Holds the FSM state encoding and the symbol width.
package simon_pkg;

    localparam int SYM_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        APPEND,
        SHOW,
        GAP,
        INPUT,
        WIN,
        LOSE
    } state_t;

endpackage

// File: rtl/simon_sequencer_if.sv
// Game-side bundle of the simon sequencer: generator request,
// player keys, display drive and win/lose status.
interface simon_sequencer_if #(
    parameter int MAX_LEN = 16
);
    import simon_pkg::*;

    localparam int LW = $clog2(MAX_LEN + 1);

    logic             start;
    logic [SYM_W-1:0] rand_in;
    logic             go1;
    logic             key_valid;
    logic [SYM_W-1:0] key;
    logic             disp_en;
    logic [SYM_W-1:0] disp_val;
    logic [LW-1:0]    round_len;
    logic             busy;
    logic             win;
    logic             lose;

    modport master (
        output start, rand_in, key_valid, key,
        input  go1, disp_en, disp_val, round_len,
        input  busy, win, lose
    );

    modport slave (
        input  start, rand_in, key_valid, key,
        output go1, disp_en, disp_val, round_len,
        output busy, win, lose
    );

endinterface

// File: rtl/simon_sequencer_tick_timer.sv
// Loadable down-counter; done_o is high while the count is zero.
// Shared by the SHOW and GAP phases of the sequencer.
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/simon_sequencer.sv
// Memory-game sequencer: appends a random symbol each round,
// replays the sequence on the display, then checks player keys.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int SHOW_TICKS = 25_000_000,
    parameter int GAP_TICKS  = 12_500_000
) (
    input  logic              clk,
    input  logic              reset_n,
    simon_sequencer_if.slave  bus
);

    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int IW   = $clog2(MAX_LEN);
    localparam int TMAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] SHOW_LD = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_TICKS - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
    localparam logic [LW-1:0] ONE     = LW'(1);

    state_t           state_q;
    state_t           state_d;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    len_d;
    logic [LW-1:0]    idx_q;
    logic [LW-1:0]    idx_d;
    logic [SYM_W-1:0] mem_q [MAX_LEN];

    logic [SYM_W-1:0] cur_sym;
    logic             at_last;
    logic             t_done;
    logic             t_load;
    logic             t_en;
    logic [TW-1:0]    t_val;

    assign cur_sym = mem_q[idx_q[IW-1:0]];
    assign at_last = (idx_q == (len_q - ONE));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE, WIN, LOSE: begin
                if (bus.start) begin
                    state_d = APPEND;
                    len_d   = '0;
                    idx_d   = '0;
                end
            end
            APPEND: begin
                len_d   = len_q + ONE;
                idx_d   = '0;
                state_d = SHOW;
            end
            SHOW: begin
                if (t_done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (t_done) begin
                    if (at_last) begin
                        idx_d   = '0;
                        state_d = INPUT;
                    end else begin
                        idx_d   = idx_q + ONE;
                        state_d = SHOW;
                    end
                end
            end
            INPUT: begin
                if (bus.key_valid) begin
                    if (bus.key != cur_sym) begin
                        state_d = LOSE;
                    end else if (!at_last) begin
                        idx_d = idx_q + ONE;
                    end else if (len_q == LEN_MAX) begin
                        state_d = WIN;
                    end else begin
                        state_d = APPEND;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timer is reloaded on entry to SHOW or GAP, so it never carries over.
    assign t_load = (state_d != state_q) &&
                    ((state_d == SHOW) || (state_d == GAP));
    assign t_val  = (state_d == SHOW) ? SHOW_LD : GAP_LD;
    assign t_en   = (state_q == SHOW) || (state_q == GAP);

    tick_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (t_load),
        .load_val_i (t_val),
        .en_i       (t_en),
        .done_o     (t_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // Contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (state_q == APPEND) begin
            mem_q[len_q[IW-1:0]] <= bus.rand_in;
        end
    end

    always_comb begin
        bus.go1       = 1'b0;
        bus.disp_en   = 1'b0;
        bus.disp_val  = '0;
        bus.busy      = 1'b0;
        bus.win       = 1'b0;
        bus.lose      = 1'b0;
        bus.round_len = len_q;
        unique case (1'b1)
            (state_q == APPEND): begin
                bus.go1  = 1'b1;
                bus.busy = 1'b1;
            end
            (state_q == SHOW): begin
                bus.disp_en  = 1'b1;
                bus.disp_val = cur_sym;
                bus.busy     = 1'b1;
            end
            (state_q == GAP):  bus.busy = 1'b1;
            (state_q == WIN):  bus.win  = 1'b1;
            (state_q == LOSE): bus.lose = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: cycle table for the first round plus
// model-driven games with random symbols, keys and mistakes.
module tb_simon_sequencer;

    localparam int ML = 4;
    localparam int ST = 4;
    localparam int GT = 2;

    logic clk = 1'b0;
    logic reset_n;

    simon_sequencer_if #(.MAX_LEN(ML)) bus ();

    simon_sequencer #(
        .MAX_LEN    (ML),
        .SHOW_TICKS (ST),
        .GAP_TICKS  (GT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int go1_cnt = 0;
    logic [1:0] model_q[$];

    typedef struct {
        logic        start;
        logic [1:0]  rnd;
        logic        kv;
        logic [1:0]  key;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    always @(posedge clk) begin
        #2;
        if (bus.go1 === 1'b1) go1_cnt++;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] pk(input int g, input int e,
                                       input int v, input int b,
                                       input int w, input int l,
                                       input int rl);
        return 32'({1'(g), 1'(e), 2'(v), 1'(b), 1'(w), 1'(l), 3'(rl)});
    endfunction

    function automatic logic [31:0] outs();
        return 32'({bus.go1, bus.disp_en, bus.disp_val, bus.busy,
                    bus.win, bus.lose, bus.round_len});
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        bus.start = 1'b0;
        bus.key_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic noise();
        bus.key_valid = ($urandom_range(0, 5) == 0);
        bus.key = 2'($urandom);
        bus.start = ($urandom_range(0, 7) == 0);
    endtask

    task automatic replay();
        foreach (model_q[k]) begin
            repeat (ST) begin
                @(negedge clk);
                chk("show", outs(),
                    pk(0, 1, model_q[k], 1, 0, 0, model_q.size()));
                noise();
            end
            repeat (GT) begin
                @(negedge clk);
                chk("gap", outs(), pk(0, 0, 0, 1, 0, 0, model_q.size()));
                noise();
            end
        end
    endtask

    task automatic play_game(input logic [7:0] syms, input int bad_r,
                             input int bad_i, input logic [1:0] bad_x,
                             input int rst_r);
        int base;
        logic bad;
        model_q.delete();
        base = go1_cnt;
        bus.start = 1'b1;
        bus.rand_in = syms[1:0];
        @(negedge clk);
        bus.start = 1'b0;
        chk("start", outs(), pk(1, 0, 0, 1, 0, 0, 0));
        for (int r = 1; r <= ML; r++) begin
            bus.rand_in = syms[2*(r-1) +: 2];
            model_q.push_back(syms[2*(r-1) +: 2]);
            if (r == rst_r) begin
                repeat (ST + 1) @(negedge clk);
                reset_n = 1'b0;
                #1;
                chk("mid_reset", outs(), 32'd0);
                return;
            end
            replay();
            @(negedge clk);
            bus.key_valid = 1'b0;
            bus.start = 1'b0;
            chk("input", outs(), pk(0, 0, 0, 0, 0, 0, r));
            for (int i = 0; i < r; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bad = (r == bad_r) && (i == bad_i);
                bus.key = bad ? (model_q[i] ^ bad_x) : model_q[i];
                bus.key_valid = 1'b1;
                @(negedge clk);
                bus.key_valid = 1'b0;
                bus.key = 2'($urandom);
                if (bad) begin
                    chk("lose", outs(), pk(0, 0, 0, 0, 0, 1, r));
                    return;
                end
                if (i < r - 1) begin
                    chk("key_mid", outs(), pk(0, 0, 0, 0, 0, 0, r));
                end else if (r == ML) begin
                    chk("win", outs(), pk(0, 0, 0, 0, 1, 0, ML));
                    chk("go1_count", 32'(go1_cnt - base), 32'(ML));
                    return;
                end else begin
                    chk("next_round", outs(), pk(1, 0, 0, 1, 0, 0, r));
                end
            end
        end
    endtask

    initial begin
        int br;
        int bi;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.rand_in = 2'd0;
        bus.key_valid = 1'b0;
        bus.key = 2'd0;

        tbl[0]  = '{1'b0, 2'd0, 1'b0, 2'd0, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b1, 2'd2, 1'b0, 2'd0, pk(1, 0, 0, 1, 0, 0, 0)};
        tbl[2]  = '{1'b0, 2'd2, 1'b0, 2'd0, pk(0, 1, 2, 1, 0, 0, 1)};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 2'd1, pk(0, 1, 2, 1, 0, 0, 1)};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 2'd0, pk(0, 1, 2, 1, 0, 0, 1)};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 2'd3, pk(0, 1, 2, 1, 0, 0, 1)};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 2'd0, pk(0, 0, 0, 1, 0, 0, 1)};
        tbl[7]  = '{1'b1, 2'd0, 1'b0, 2'd0, pk(0, 0, 0, 1, 0, 0, 1)};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 2'd2, pk(0, 0, 0, 0, 0, 0, 1)};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 2'd1, pk(0, 0, 0, 0, 0, 1, 1)};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 2'd2, pk(0, 0, 0, 0, 0, 1, 1)};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 2'd0, pk(1, 0, 0, 1, 0, 0, 0)};

        repeat (2) @(negedge clk);
        chk("reset", outs(), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus.start = tbl[i].start;
            bus.rand_in = tbl[i].rnd;
            bus.key_valid = tbl[i].kv;
            bus.key = tbl[i].key;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // full correct game with symbols 1,3,0,2
        do_reset();
        play_game(8'h8D, 0, 0, 2'd0, 0);

        // sequence 1,3: keys 1 then 0 in round 2
        do_reset();
        play_game(8'h0D, 2, 1, 2'd3, 0);
        repeat (3) @(negedge clk);
        chk("lose_hold", outs(), pk(0, 0, 0, 0, 0, 1, 2));

        // restart straight from LOSE into a fresh game
        play_game(8'($urandom), 0, 0, 2'd0, 0);

        // reset during GAP of round 3
        do_reset();
        play_game(8'($urandom), 0, 0, 2'd0, 3);
        @(negedge clk);
        chk("reset_hold", outs(), 32'd0);
        reset_n = 1'b1;
        bus.start = 1'b1;
        bus.rand_in = 2'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("post_reset_go1", outs(), pk(1, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        chk("post_reset_len", outs(), pk(0, 1, 1, 1, 0, 0, 1));
        do_reset();

        for (int g = 0; g < 16; g++) begin
            br = $urandom_range(0, ML);
            bi = (br > 0) ? $urandom_range(0, br - 1) : 0;
            play_game(8'($urandom), br, bi, 2'($urandom_range(1, 3)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
